imem_loader: RTL
================

Name: imem_loader

Overview:
- Byte-stream program loader: the write-side counterpart of the 256-word read-only instruction memory.
- Receives a framed byte stream, for example from a UART receiver or a debug port.
- Assembles little-endian 32-bit instruction words and drives the instruction memory's write port at byte addresses 0, 4, 8, …
- Holds the core in reset until a complete, checksum-verified image is loaded.

Parameters:
- ADDR_W, 8: word-index width. Capacity is 2^ADDR_W words; byte address bits [ADDR_W+1:2] select the word.
- MAGIC, 8'hA5: frame start byte.
- TIMEOUT, 50000: maximum idle cycles between bytes inside a frame before abort. Must be at least 2.
- HOLD_AT_RESET, 1: reset value of cpu_hold.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input byte valid.
- s_data  in  8  input byte.
- s_ready  out  1  loader can accept a byte.
- mem_we  out  1  single-cycle instruction-memory write strobe.
- mem_waddr  out  32  write byte address; bits [1:0] always 0.
- mem_wdata  out  32  write data word.
- busy  out  1  frame in progress.
- done  out  1  last frame loaded and verified (sticky).
- err  out  1  last frame aborted (sticky).
- cpu_hold  out  1  hold the core in reset/stall.

Behaviour:
- Reset values: s_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_hold=HOLD_AT_RESET, state=IDLE, all counters 0.
- Reset asserted mid-frame abandons the frame immediately. Writes already issued are not undone.
- Handshake: a byte transfers on a rising edge with s_valid && s_ready. s_ready=1 in every state once out of reset, so there is no backpressure. s_data is ignored when s_valid=0.
- Frame format: MAGIC, CNT_LO, CNT_HI, then N×4 data bytes (least-significant byte first), then CSUM.
  - N = {CNT_HI, CNT_LO}.
  - CSUM = XOR of all data bytes only (0x00 when N=0).
- FSM states: IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR.
- IDLE / DONE / ERR:
  - A byte equal to MAGIC goes to CNT_LO.
  - On that transition: clear done, err, word counter, byte index and XOR accumulator; set mem_waddr=0, busy=1, cpu_hold=1.
  - Any other byte is discarded with no state change.
- CNT_LO: latch the low count byte, go to CNT_HI.
- CNT_HI: latch the high count byte, then:
  - N > 2^ADDR_W goes to ERR.
  - N = 0 goes to CSUM.
  - Otherwise go to DATA.
- DATA:
  - A 2-bit byte index places each byte at word[8*idx+7 : 8*idx], and each byte is XORed into the accumulator.
  - When byte idx=3 is accepted, the next cycle shows mem_we=1 with mem_wdata = the completed word and mem_waddr = the current word address. This write latency is 1 cycle.
  - After the write strobe, mem_waddr increments by 4 and the word counter increments.
  - A new byte accepted in the same cycle as the strobe is legal; the assembly register must not corrupt the pending word.
  - After the Nth word's byte 3 is accepted, go to CSUM.
- CSUM:
  - A byte equal to the accumulator goes to DONE: the cycle after acceptance shows done=1, busy=0, cpu_hold=0.
  - A mismatch goes to ERR: err=1, busy=0, cpu_hold stays 1.
- Timeout: in CNT_LO, CNT_HI, DATA and CSUM, an idle counter resets on every accepted byte. When the counter reaches TIMEOUT, go to ERR (err=1, busy=0, cpu_hold=1). A partially assembled word is never written.
- Wrap-around: when N = 2^ADDR_W, the final write is at (2^ADDR_W − 1)×4. No write ever occurs at or beyond 2^ADDR_W words.
- mem_we is never asserted outside DATA-completed words, is never asserted for two consecutive cycles, and is not asserted in ERR.
- A MAGIC value appearing inside CNT/DATA/CSUM is treated as ordinary payload, not a restart.

Test Plan:
1. Byte stream A5 02 00 13 01 50 00 93 01 A0 00 70, one byte per cycle -> mem_we pulses twice:
   - first pulse: addr 0x0, data 0x00500113;
   - second pulse: addr 0x4, data 0x00A00193;
   - then done=1, err=0, cpu_hold=0; busy=1 from the cycle after A5 until done.
2. Same stream with CSUM 0x71 -> both writes occur, then err=1, done=0, cpu_hold=1.
3. Stream 00 FF A5 00 00 00 -> leading bytes ignored, no writes, done=1.
4. A5 01 00 13 01, then 20 idle cycles with TIMEOUT=16 -> err=1 at idle count 16, no mem_we, busy=0.
5. A5 with N=0x0101 (257) at ADDR_W=8 -> err=1 after CNT_HI, no writes. Then a valid N=1 frame -> err clears, done=1, single write at addr 0x0.
6. s_valid gaps and a payload byte equal to A5 mid-DATA, plus rst_n pulsed low after 2 of 4 bytes -> gaps do not change assembly, A5 is treated as data, and reset returns all outputs to reset values within the same cycle.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream program loader for the instruction memory.
// Frame: MAGIC, CNT_LO, CNT_HI, N little-endian 32-bit words, XOR checksum.
module imem_loader #(
    parameter int unsigned ADDR_W        = 8,
    parameter logic [7:0]  MAGIC         = 8'hA5,
    parameter int unsigned TIMEOUT       = 50000,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    localparam int unsigned       TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LIM = TO_W'(TIMEOUT - 1);
    localparam logic [16:0]       CAP    = 17'(32'd1 << ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    function automatic logic [7:0] f_csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t           r_state,     w_state_nxt;
    logic             r_s_ready;
    logic             r_mem_we,    w_mem_we_nxt;
    logic [31:0]      r_mem_waddr, w_mem_waddr_nxt;
    logic [31:0]      r_mem_wdata, w_mem_wdata_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_done,      w_done_nxt;
    logic             r_err,       w_err_nxt;
    logic             r_hold,      w_hold_nxt;
    logic [7:0]       r_cnt_lo,    w_cnt_lo_nxt;
    logic [15:0]      r_n,         w_n_nxt;
    logic [16:0]      r_word_cnt,  w_word_cnt_nxt;
    logic [1:0]       r_byte_idx,  w_byte_idx_nxt;
    logic [7:0]       r_xor,       w_xor_nxt;
    logic [23:0]      r_asm,       w_asm_nxt;
    logic [TO_W-1:0]  r_idle,      w_idle_nxt;

    logic             w_accept;
    logic             w_active;
    logic             w_last_word;
    logic [15:0]      w_count;

    assign w_accept    = s_valid & r_s_ready;
    assign w_active    = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) ||
                         (r_state == S_DATA)   || (r_state == S_CSUM);
    assign w_last_word = ((r_word_cnt + 17'd1) == {1'b0, r_n});
    assign w_count     = {s_data, r_cnt_lo};

    // Next-state and next-output computation for the whole loader
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_we_nxt    = 1'b0;
        w_mem_waddr_nxt = r_mem_waddr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_err_nxt       = r_err;
        w_hold_nxt      = r_hold;
        w_cnt_lo_nxt    = r_cnt_lo;
        w_n_nxt         = r_n;
        w_word_cnt_nxt  = r_word_cnt;
        w_byte_idx_nxt  = r_byte_idx;
        w_xor_nxt       = r_xor;
        w_asm_nxt       = r_asm;
        w_idle_nxt      = r_idle;

        // The address advances only once the strobed word has been presented.
        if (r_mem_we) begin
            w_mem_waddr_nxt = r_mem_waddr + 32'd4;
            w_word_cnt_nxt  = r_word_cnt + 17'd1;
        end else begin
            w_mem_waddr_nxt = r_mem_waddr;
        end

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_accept && (s_data == MAGIC)) begin
                    w_state_nxt     = S_CNT_LO;
                    w_done_nxt      = 1'b0;
                    w_err_nxt       = 1'b0;
                    w_word_cnt_nxt  = 17'd0;
                    w_byte_idx_nxt  = 2'd0;
                    w_xor_nxt       = 8'h00;
                    w_mem_waddr_nxt = 32'd0;
                    w_busy_nxt      = 1'b1;
                    w_hold_nxt      = 1'b1;
                    w_idle_nxt      = '0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_CNT_LO: begin
                if (w_accept) begin
                    w_cnt_lo_nxt = s_data;
                    w_idle_nxt   = '0;
                    w_state_nxt  = S_CNT_HI;
                end else begin
                    w_state_nxt = S_CNT_LO;
                end
            end
            S_CNT_HI: begin
                if (w_accept) begin
                    w_n_nxt    = w_count;
                    w_idle_nxt = '0;
                    if ({1'b0, w_count} > CAP) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_hold_nxt  = 1'b1;
                    end else if (w_count == 16'd0) begin
                        w_state_nxt = S_CSUM;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_state_nxt = S_CNT_HI;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_idle_nxt     = '0;
                    w_xor_nxt      = f_csum_step(r_xor, s_data);
                    w_byte_idx_nxt = r_byte_idx + 2'd1;
                    case (r_byte_idx)
                        2'd0: w_asm_nxt[7:0]   = s_data;
                        2'd1: w_asm_nxt[15:8]  = s_data;
                        2'd2: w_asm_nxt[23:16] = s_data;
                        2'd3: begin
                            // Completed word moves to the write register; r_asm is free again.
                            w_mem_we_nxt    = 1'b1;
                            w_mem_wdata_nxt = {s_data, r_asm};
                            if (w_last_word) begin
                                w_state_nxt = S_CSUM;
                            end else begin
                                w_state_nxt = S_DATA;
                            end
                        end
                        default: w_asm_nxt = r_asm;
                    endcase
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_idle_nxt = '0;
                    w_busy_nxt = 1'b0;
                    if (s_data == r_xor) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_hold_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 1'b1;
                        w_hold_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_CSUM;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_active && !w_accept) begin
            if (r_idle == TO_LIM) begin
                w_state_nxt = S_ERR;
                w_err_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
                w_hold_nxt  = 1'b1;
                w_idle_nxt  = '0;
            end else begin
                w_idle_nxt = r_idle + TO_W'(1);
            end
        end else begin
            w_idle_nxt = w_idle_nxt;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_s_ready   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_hold      <= HOLD_AT_RESET;
            r_cnt_lo    <= 8'h00;
            r_n         <= 16'd0;
            r_word_cnt  <= 17'd0;
            r_byte_idx  <= 2'd0;
            r_xor       <= 8'h00;
            r_asm       <= 24'd0;
            r_idle      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_s_ready   <= 1'b1;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_waddr <= w_mem_waddr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_hold      <= w_hold_nxt;
            r_cnt_lo    <= w_cnt_lo_nxt;
            r_n         <= w_n_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_xor       <= w_xor_nxt;
            r_asm       <= w_asm_nxt;
            r_idle      <= w_idle_nxt;
        end
    end

    assign s_ready   = r_s_ready;
    assign mem_we    = r_mem_we;
    assign mem_waddr = r_mem_waddr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign cpu_hold  = r_hold;

endmodule
